ltl_cluster_monitor: RTL and testbench
======================================

Name: ltl_cluster_monitor

Overview:
Parametrised report-aggregation and event-logging stage for one monitor cluster. It sits behind a cluster's automata stage and consumes the raw per-report-state hit lines. It produces:
- per-property violation flags, both registered and sticky;
- per-property saturating violation counters;
- a buffered event stream (hit mask plus optional timestamp) with valid/ready handshake toward the host or trace path.

Parameters:
NUM_LTL, 9, number of LTL properties monitored by the cluster
NUM_RPT, 4, report states per property (OR-reduced per property)
CNT_W, 16, width of each per-property violation counter
FIFO_DEPTH, 8, event FIFO entries; power of two, >=2
TS_W, 32, timestamp width (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
run  in  1  monitor enable; gates hit sampling and timestamp advance
clear  in  1  synchronous clear of sticky flags, counters, FIFO, overflow, timestamp
report_in  in  NUM_LTL*NUM_RPT  raw report hits; bit [l*NUM_RPT+r] = property l, report state r
ltl_hit  out  NUM_LTL  registered per-property hit
ltl_sticky  out  NUM_LTL  sticky per-property hit
ltl_cnt  out  NUM_LTL*CNT_W  per-property counters, property l at [l*CNT_W +: CNT_W]
evt_valid  out  1  FIFO head valid
evt_ready  in  1  consumer accepts head
evt_mask  out  NUM_LTL  hit mask of head entry
evt_ts  out  TS_W  timestamp of head entry (present only with LTL_MON_TIMESTAMP_EN)
evt_overflow  out  1  sticky: at least one event dropped
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous, active-high on reset): all outputs 0; FIFO empty; timestamp 0.
- Hit mask:
  - hit_now[l] = run & OR over r of report_in[l*NUM_RPT+r].
  - ltl_hit <= hit_now every cycle, so latency is 1 cycle.
  - When run=0, ltl_hit is 0 on the next cycle.
- ltl_sticky <= ltl_sticky | hit_now.
- ltl_cnt[l] increments by 1 when hit_now[l] is set and saturates at all-ones. It never wraps.
- Push: when hit_now != 0, the entry {hit_now, ts} is written. It is visible at the FIFO head on the next cycle at the earliest.
- Pop: a pop occurs on evt_valid & evt_ready.
  - evt_mask/evt_ts hold stable while evt_valid=1 and evt_ready=0.
  - evt_valid = (level != 0).
- Empty FIFO with a push: evt_valid rises the following cycle. There is no same-cycle bypass.
- Full FIFO:
  - Push with a simultaneous pop: push accepted, level unchanged.
  - Push without a pop: entry dropped, evt_overflow set (sticky until clear/reset), level stays FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH. Level is tracked with an extra bit, so full and empty are distinguishable.
- run=0:
  - no sampling and no pushes;
  - counters and sticky flags hold;
  - the FIFO continues to drain through the handshake.
- clear (highest priority after reset):
  - next cycle: sticky flags, counters, overflow, FIFO level and pointers, and timestamp are 0;
  - ltl_hit is 0;
  - hits and a pop in the clear cycle are discarded.
- Timestamp: internal counter that increments by 1 on every cycle with run=1 and wraps modulo 2^TS_W. An entry carries the counter value of its sample cycle.
- Reset asserted mid-operation: everything returns to its reset value immediately, including pending FIFO entries.

Optional Feature:
- Macro: LTL_MON_TIMESTAMP_EN.
- Defined: the timestamp counter exists, FIFO entries are NUM_LTL+TS_W bits wide, and the evt_ts port is present.
- Undefined: no timestamp counter, no evt_ts port, and FIFO entries are NUM_LTL bits wide. All other behaviour is identical.

Decomposition:
- Package ltl_mon_pkg holds:
  - default parameter constants;
  - the function computing the level width, $clog2(FIFO_DEPTH)+1;
  - the event entry packing/unpacking helpers, i.e. mask offsets and the timestamp field offset.
- Sub-module ltl_evt_fifo: synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: push, push_data, full, pop, head_data, empty, level, clear.
  - Asynchronous active-high reset.
  - The overflow flag and the drop decision stay in the parent.

Test Plan:
1. Reset, then run=1 with report_in bit 6 (NUM_RPT=4, so property 1, r=2) for one cycle -> ltl_hit=9'h002 one cycle later, then 0; ltl_sticky=9'h002; ltl_cnt[1]=1; one FIFO entry with mask 9'h002.
2. run=0 with all report_in bits high for 5 cycles -> ltl_hit=0, counters unchanged, fifo_level unchanged, timestamp frozen.
3. evt_ready=0 and 10 consecutive single-property hits (FIFO_DEPTH=8) -> fifo_level=8, evt_overflow=1, first 8 masks drained in order once evt_ready=1.
4. FIFO full, push with simultaneous pop -> level stays 8, evt_overflow stays 0, new entry is the tail.
5. CNT_W=4 and property 0 hit for 20 cycles -> ltl_cnt[0] saturates at 4'hF.
6. LTL_MON_TIMESTAMP_EN defined; run=1 for 7 cycles, then a hit -> entry evt_ts=7. Assert clear with a hit in the same cycle -> all state 0, no entry pushed.

Source files
------------

// File: rtl/ltl_mon_pkg.sv
// Shared constants and event-entry layout helpers for the LTL cluster monitor.
package ltl_mon_pkg;

  localparam int unsigned LTL_NUM_DEF    = 9;
  localparam int unsigned LTL_RPT_DEF    = 4;
  localparam int unsigned LTL_CNT_W_DEF  = 16;
  localparam int unsigned LTL_FIFO_DEF   = 8;
  localparam int unsigned LTL_TS_W_DEF   = 32;

  // Occupancy width: one extra bit so a full FIFO is distinct from an empty one.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Event entry layout: hit mask in the low bits, timestamp (if any) above it.
  function automatic int unsigned evt_mask_lsb();
    return 0;
  endfunction

  function automatic int unsigned evt_ts_lsb(input int unsigned num_ltl);
    return num_ltl;
  endfunction

  function automatic int unsigned evt_entry_w(input int unsigned num_ltl,
                                              input int unsigned ts_w,
                                              input bit          ts_en);
    return ts_en ? (num_ltl + ts_w) : num_ltl;
  endfunction

endpackage

// File: rtl/ltl_evt_fifo.sv
// Synchronous event FIFO with occupancy count and synchronous clear.
module ltl_evt_fifo
  import ltl_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  output logic                    full,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head_data,
  output logic                    empty,
  output logic [lvl_w(DEPTH)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = lvl_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic             full_q,   full_d;
  logic             empty_q,  empty_d;
  logic             wr_en;
  logic             rd_en;

  // Full-with-pop is allowed to write: the slot frees in the same cycle.
  always_comb begin
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      rd_en    = pop & ~empty_q;
      wr_en    = push & (~full_q | rd_en);
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
      level_d  = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
    end
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: contents are only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    head_data = '0;
    if (!empty_q) head_data = mem_q[rd_ptr_q];
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign level = level_q;

endmodule

// File: rtl/ltl_cluster_monitor.sv
// Per-cluster LTL report aggregation: hit/sticky flags, saturating counters, event FIFO.
// Define LTL_MON_TIMESTAMP_EN to add a run-time timestamp to each event (evt_ts port).
module ltl_cluster_monitor
  import ltl_mon_pkg::*;
#(
  parameter int unsigned NUM_LTL    = LTL_NUM_DEF,
  parameter int unsigned NUM_RPT    = LTL_RPT_DEF,
  parameter int unsigned CNT_W      = LTL_CNT_W_DEF,
  parameter int unsigned FIFO_DEPTH = LTL_FIFO_DEF,
  parameter int unsigned TS_W       = LTL_TS_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         clear,
  input  logic [NUM_LTL*NUM_RPT-1:0]   report_in,
  output logic [NUM_LTL-1:0]           ltl_hit,
  output logic [NUM_LTL-1:0]           ltl_sticky,
  output logic [NUM_LTL*CNT_W-1:0]     ltl_cnt,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [NUM_LTL-1:0]           evt_mask,
`ifdef LTL_MON_TIMESTAMP_EN
  output logic [TS_W-1:0]              evt_ts,
`endif
  output logic                         evt_overflow,
  output logic [lvl_w(FIFO_DEPTH)-1:0] fifo_level
);

`ifdef LTL_MON_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
  localparam int unsigned TS_LSB = evt_ts_lsb(NUM_LTL);
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int unsigned ENTRY_W  = evt_entry_w(NUM_LTL, TS_W, TS_EN);
  localparam int unsigned MASK_LSB = evt_mask_lsb();

  logic [NUM_LTL-1:0]             hit_now;
  logic [NUM_LTL-1:0]             hit_q,    hit_d;
  logic [NUM_LTL-1:0]             sticky_q, sticky_d;
  logic [NUM_LTL-1:0][CNT_W-1:0]  cnt_q,    cnt_d;
  logic                           ovf_q,    ovf_d;
`ifdef LTL_MON_TIMESTAMP_EN
  logic [TS_W-1:0]                ts_q,     ts_d;
`endif

  logic               push_req;
  logic               pop_req;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;

  // Per-property OR of its report states, gated by run.
  always_comb begin
    hit_now = '0;
    for (int unsigned l = 0; l < NUM_LTL; l++) begin
      hit_now[l] = run & (|report_in[l*NUM_RPT +: NUM_RPT]);
    end
  end

  always_comb begin
    push_req  = ~clear & (|hit_now);
    pop_req   = ~clear & ~fifo_empty & evt_ready;
    push_data = '0;
    push_data[MASK_LSB +: NUM_LTL] = hit_now;
`ifdef LTL_MON_TIMESTAMP_EN
    push_data[TS_LSB +: TS_W] = ts_q;
`endif
  end

  // Next-state for flags and counters; clear wins over any activity this cycle.
  always_comb begin
    hit_d    = hit_now;
    sticky_d = sticky_q | hit_now;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q | (push_req & fifo_full & ~pop_req);
`ifdef LTL_MON_TIMESTAMP_EN
    ts_d     = run ? ts_q + TS_W'(1) : ts_q;
`endif
    for (int unsigned l = 0; l < NUM_LTL; l++) begin
      if (hit_now[l] && (cnt_q[l] != '1)) cnt_d[l] = cnt_q[l] + CNT_W'(1);
    end
    if (clear) begin
      hit_d    = '0;
      sticky_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
`ifdef LTL_MON_TIMESTAMP_EN
      ts_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q    <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef LTL_MON_TIMESTAMP_EN
      ts_q     <= '0;
`endif
    end else begin
      hit_q    <= hit_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
`ifdef LTL_MON_TIMESTAMP_EN
      ts_q     <= ts_d;
`endif
    end
  end

  ltl_evt_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push_req),
    .push_data (push_data),
    .full      (fifo_full),
    .pop       (pop_req),
    .head_data (head_data),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign ltl_hit      = hit_q;
  assign ltl_sticky   = sticky_q;
  assign ltl_cnt      = cnt_q;
  assign evt_overflow = ovf_q;
  assign evt_valid    = ~fifo_empty;
  assign evt_mask     = head_data[MASK_LSB +: NUM_LTL];
`ifdef LTL_MON_TIMESTAMP_EN
  assign evt_ts       = head_data[TS_LSB +: TS_W];
`endif

endmodule

// File: tb/tb_ltl_cluster_monitor.sv
// Randomised self-checking bench for ltl_cluster_monitor against a queue-based reference model.
module tb_ltl_cluster_monitor;

  localparam int unsigned NL  = 9;
  localparam int unsigned NR  = 4;
  localparam int unsigned CW  = 4;
  localparam int unsigned FD  = 8;
  localparam int unsigned TW  = 32;
  localparam int unsigned LW  = $clog2(FD) + 1;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                run;
  logic                clear;
  logic [NL*NR-1:0]    report_in;
  logic [NL-1:0]       ltl_hit;
  logic [NL-1:0]       ltl_sticky;
  logic [NL*CW-1:0]    ltl_cnt;
  logic                evt_valid;
  logic                evt_ready;
  logic [NL-1:0]       evt_mask;
`ifdef LTL_MON_TIMESTAMP_EN
  logic [TW-1:0]       evt_ts;
`endif
  logic                evt_overflow;
  logic [LW-1:0]       fifo_level;

  ltl_cluster_monitor #(
    .NUM_LTL(NL), .NUM_RPT(NR), .CNT_W(CW), .FIFO_DEPTH(FD), .TS_W(TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .clear        (clear),
    .report_in    (report_in),
    .ltl_hit      (ltl_hit),
    .ltl_sticky   (ltl_sticky),
    .ltl_cnt      (ltl_cnt),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_mask     (evt_mask),
`ifdef LTL_MON_TIMESTAMP_EN
    .evt_ts       (evt_ts),
`endif
    .evt_overflow (evt_overflow),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL-1:0] mask;
    logic [TW-1:0] ts;
  } evt_t;

  evt_t          m_q[$];
  logic [NL-1:0] m_hit;
  logic [NL-1:0] m_sticky;
  int unsigned   m_cnt[NL];
  logic          m_ovf;
  logic [TW-1:0] m_ts;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hit    = '0;
    m_sticky = '0;
    m_ovf    = 1'b0;
    m_ts     = '0;
    for (int l = 0; l < NL; l++) m_cnt[l] = 0;
  endtask

  task automatic model_step(input logic r, input logic c, input logic [NL*NR-1:0] rep,
                            input logic rdy);
    logic [NL-1:0] hit;
    bit            pop;
    evt_t          e;
    hit = '0;
    if (r) for (int l = 0; l < NL; l++) hit[l] = |rep[l*NR +: NR];
    if (c) begin
      model_reset();
    end else begin
      pop      = (m_q.size() != 0) && rdy;
      m_hit    = hit;
      m_sticky = m_sticky | hit;
      for (int l = 0; l < NL; l++)
        if (hit[l] && m_cnt[l] < CMAX) m_cnt[l]++;
      if (pop) void'(m_q.pop_front());
      if (hit != '0) begin
        if (m_q.size() < FD) begin
          e.mask = hit;
          e.ts   = m_ts;
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (r) m_ts = m_ts + 1;
    end
  endtask

  task automatic check_all();
    logic [NL*CW-1:0] exp_cnt;
    for (int l = 0; l < NL; l++) exp_cnt[l*CW +: CW] = CW'(m_cnt[l]);
    chk("ltl_hit", 64'(ltl_hit), 64'(m_hit));
    chk("ltl_sticky", 64'(ltl_sticky), 64'(m_sticky));
    chk("ltl_cnt", 64'(ltl_cnt), 64'(exp_cnt));
    chk("evt_valid", 64'(evt_valid), 64'(m_q.size() != 0));
    chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    chk("evt_overflow", 64'(evt_overflow), 64'(m_ovf));
    if (m_q.size() != 0) begin
      chk("evt_mask", 64'(evt_mask), 64'(m_q[0].mask));
`ifdef LTL_MON_TIMESTAMP_EN
      chk("evt_ts", 64'(evt_ts), 64'(m_q[0].ts));
`endif
    end
  endtask

  // Drive at the falling edge, advance the model, check 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic c, input logic [NL*NR-1:0] rep,
                       input logic rdy);
    run = r; clear = c; report_in = rep; evt_ready = rdy;
    model_step(r, c, rep, rdy);
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  function automatic logic [NL*NR-1:0] one_prop(input int l, input int r);
    logic [NL*NR-1:0] v;
    v = '0;
    v[l*NR + r] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [63:0]      rnd;
    logic [NL*NR-1:0] rep;
    logic [NL*NR-1:0] all_ones;
    all_ones  = '1;
    reset = 1'b1; run = 1'b0; clear = 1'b0; report_in = '0; evt_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b0;

    // Single report hit on property 1, state 2 (bit 6).
    cycle(1'b1, 1'b0, one_prop(1, 2), 1'b0);
    chk("tp1_hit", 64'(ltl_hit), 64'h002);
    chk("tp1_cnt1", 64'(ltl_cnt[CW +: CW]), 64'd1);
    chk("tp1_mask", 64'(evt_mask), 64'h002);
    cycle(1'b1, 1'b0, '0, 1'b0);
    chk("tp1_hit_drop", 64'(ltl_hit), 64'h000);
    chk("tp1_sticky", 64'(ltl_sticky), 64'h002);

    // run=0 ignores every report bit.
    repeat (5) cycle(1'b0, 1'b0, all_ones, 1'b0);
    chk("tp2_level", 64'(fifo_level), 64'd1);

    // Overflow: ten hits into an eight-entry FIFO with no consumer, then drain.
    cycle(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, one_prop(i % NL, i % NR), 1'b0);
    chk("tp3_level", 64'(fifo_level), 64'(FD));
    chk("tp3_ovf", 64'(evt_overflow), 64'd1);
    repeat (FD + 1) cycle(1'b0, 1'b0, '0, 1'b1);

    // Full FIFO with push and pop in the same cycle.
    cycle(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < FD; i++) cycle(1'b1, 1'b0, one_prop(i % NL, 0), 1'b0);
    cycle(1'b1, 1'b0, one_prop(8, 3), 1'b1);
    chk("tp4_level", 64'(fifo_level), 64'(FD));
    chk("tp4_ovf", 64'(evt_overflow), 64'd0);
    repeat (FD) cycle(1'b0, 1'b0, '0, 1'b1);

    // Counter saturation on property 0.
    cycle(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, one_prop(0, i % NR), 1'b1);
    chk("tp5_cnt0", 64'(ltl_cnt[CW-1:0]), 64'(CMAX));

    // Timestamp of the first hit after seven idle run cycles, then clear with a hit.
    cycle(1'b0, 1'b1, '0, 1'b0);
    repeat (7) cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, one_prop(3, 1), 1'b0);
`ifdef LTL_MON_TIMESTAMP_EN
    chk("tp6_ts", 64'(evt_ts), 64'd7);
`endif
    cycle(1'b1, 1'b1, one_prop(4, 0), 1'b1);
    chk("tp6_clr_level", 64'(fifo_level), 64'd0);
    chk("tp6_clr_sticky", 64'(ltl_sticky), 64'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rnd = {$urandom, $urandom};
      rep = '0;
      if ($urandom_range(0, 2) == 0) rep = (NL*NR)'(rnd) & (NL*NR)'({$urandom, $urandom});
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 60) == 0, rep,
            $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset in the middle of activity.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, one_prop(i, 1), 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b1, 1'b0, one_prop(2, 3), 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
